// File: rtl/present_controller.sv
// ---------------------------------------------------------------------------
// present_controller
//
// Spawns, drops, lands, expires and collects a single falling "present" power-up.
// A free-running 16-bit LFSR supplies the spawn X position and the present type.
//
// Ports:
//   clk                - system clock
//   reset              - synchronous active-high reset
//   startOfFrame       - one-cycle pulse per video frame (advances the fall)
//   secClk             - one-cycle pulse per second (ages a landed present)
//   presentDrop        - spawn request from the game state machine
//   presentsVisible    - high while in play mode; low forces IDLE
//   col_player_present - raw player/present pixel overlap
//   presentX           - present top-left X (11 bit)
//   presentY           - present top-left Y (11 bit)
//   presentType        - 00 lives, 01 super rope, 10 super speed, 11 immortal
//   presentActive      - present exists (FALLING or LANDED)
//   col_present        - one-cycle collection pulse
// ---------------------------------------------------------------------------
module present_controller #(
    parameter int          FALL_SPEED = 2,
    parameter int          FLOOR_Y    = 447,
    parameter int          X_MAX      = 607,
    parameter int          LIFETIME   = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        secClk,
    input  logic        presentDrop,
    input  logic        presentsVisible,
    input  logic        col_player_present,
    output logic [10:0] presentX,
    output logic [10:0] presentY,
    output logic [1:0]  presentType,
    output logic        presentActive,
    output logic        col_present
);

    localparam logic [10:0] SPEED_L    = 11'(FALL_SPEED);
    localparam logic [10:0] FLOOR_L    = 11'(FLOOR_Y);
    localparam logic [10:0] X_MAX_L    = 11'(X_MAX);
    localparam logic [2:0]  LIFETIME_L = 3'(LIFETIME);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FALLING = 2'd1,
        LANDED  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] lfsr_reg;
    logic [2:0]  timer_reg;
    logic [10:0] present_x_reg;
    logic [10:0] present_y_reg;
    logic [1:0]  present_type_reg;
    logic        present_active_reg;
    logic        col_present_reg;

    logic        lfsr_fb;
    logic [10:0] raw_x;
    logic [10:0] spawn_x;
    logic [10:0] next_y;

    // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10)
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    // A 10-bit random value can overshoot the screen; folding by 512 keeps it
    // on-screen while staying cheap (no modulo).
    assign raw_x   = {1'b0, lfsr_reg[9:0]};
    assign spawn_x = (raw_x > X_MAX_L) ? (raw_x - 11'd512) : raw_x;

    // presentY is always < FLOOR_Y while falling, so this cannot wrap
    assign next_y  = present_y_reg + SPEED_L;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            lfsr_reg           <= LFSR_SEED;
            timer_reg          <= 3'd0;
            present_x_reg      <= 11'd0;
            present_y_reg      <= 11'd0;
            present_type_reg   <= 2'd0;
            present_active_reg <= 1'b0;
            col_present_reg    <= 1'b0;
        end else begin
            lfsr_reg        <= {lfsr_reg[14:0], lfsr_fb};
            col_present_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (presentDrop && presentsVisible) begin
                        state_reg          <= FALLING;
                        present_y_reg      <= 11'd0;
                        present_x_reg      <= spawn_x;
                        present_type_reg   <= lfsr_reg[11:10];
                        present_active_reg <= 1'b1;
                    end
                end

                FALLING, LANDED: begin
                    // Priority: mode exit, then collection, then motion/ageing.
                    // Leaving to IDLE on collection guarantees a single pulse.
                    if (!presentsVisible) begin
                        state_reg          <= IDLE;
                        present_active_reg <= 1'b0;
                    end else if (col_player_present) begin
                        state_reg          <= IDLE;
                        present_active_reg <= 1'b0;
                        col_present_reg    <= 1'b1;
                    end else if (state_reg == FALLING) begin
                        if (startOfFrame) begin
                            if (next_y >= FLOOR_L) begin
                                present_y_reg <= FLOOR_L;
                                state_reg     <= LANDED;
                                timer_reg     <= LIFETIME_L;
                            end else begin
                                present_y_reg <= next_y;
                            end
                        end
                    end else if (secClk) begin
                        // Expire on the tick that finds the timer already empty
                        if (timer_reg != 3'd0) begin
                            timer_reg <= timer_reg - 3'd1;
                        end else begin
                            state_reg          <= IDLE;
                            present_active_reg <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg          <= IDLE;
                    present_active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign presentX      = present_x_reg;
    assign presentY      = present_y_reg;
    assign presentType   = present_type_reg;
    assign presentActive = present_active_reg;
    assign col_present   = col_present_reg;

endmodule
